// File: rtl/rv_csr_pkg.sv
// Shared definitions for the machine-mode CSR / exception block.
// Holds CSR addresses, mstatus/mie/mip bit positions, mcause codes, the
// d_fun_i CSR-op encodings and the read-modify-write helper.
package rv_csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_CYCLE   = 12'hC00;
  localparam logic [11:0] CSR_TIME    = 12'hC01;
  localparam logic [11:0] CSR_CYCLEH  = 12'hC80;
  localparam logic [11:0] CSR_TIMEH   = 12'hC81;

  // mstatus / mie / mip bit indices
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIE_MEIE_BIT     = 11;
  localparam int MIP_MTIP_BIT     = 7;
  localparam int MIP_MEIP_BIT     = 11;

  // Only the two interrupt-enable bits of mie exist
  localparam logic [31:0] MIE_WMASK = 32'h0000_0880;

  // mcause values for the two interrupt sources
  localparam logic [31:0] MCAUSE_IRQ_EXT   = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_IRQ_TIMER = 32'h8000_0007;

  // d_fun_i encodings: bit 2 selects the immediate source, bits [1:0] the op
  localparam logic [2:0] FUN_CSRRW  = 3'b001;
  localparam logic [2:0] FUN_CSRRS  = 3'b010;
  localparam logic [2:0] FUN_CSRRC  = 3'b011;
  localparam logic [2:0] FUN_CSRRWI = 3'b101;
  localparam logic [2:0] FUN_CSRRSI = 3'b110;
  localparam logic [2:0] FUN_CSRRCI = 3'b111;
  localparam int         FUN_IMM_BIT = 2;

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  // New CSR value from the old value and the operand
  function automatic logic [31:0] csr_alu(input logic [1:0]  op,
                                          input logic [31:0] old_val,
                                          input logic [31:0] src);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSR_OP_WRITE: res = src;
      CSR_OP_SET:   res = old_val | src;
      CSR_OP_CLEAR: res = old_val & ~src;
      default:      res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv_csr_trap.sv
// Trap state for the machine-mode CSR block: mstatus (MIE/MPIE), mepc,
// mcause and the sticky timer-pending flag MTIP, plus trap entry and
// return-from-trap updates.
// Ports:
//   clk_i, rst_n_i   clock, synchronous active-low reset
//   trap_i           take a trap this edge (already qualified with stall)
//   trap_ext_i       external interrupt is pending-and-enabled (cause select)
//   pc_i             PC of the trapped instruction
//   eret_i           execute return-from-trap this edge (fully qualified)
//   csr_we_i         CSR write commits this edge (fully qualified)
//   csr_sel_i        CSR address of the write
//   csr_wdata_i      value being written
//   tick_i           timer tick pulse, sets MTIP regardless of stall
//   st_mie_o/st_mpie_o, mepc_o, mcause_o, mtip_o   current state
module rv_csr_trap
  import rv_csr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        trap_i,
  input  logic        trap_ext_i,
  input  logic [31:0] pc_i,
  input  logic        eret_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_sel_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        tick_i,
  output logic        st_mie_o,
  output logic        st_mpie_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic        mtip_o
);

  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        mtip_q, mtip_d;

  // Trap entry outranks return-from-trap, which outranks a CSR write.
  // In practice the callers make them mutually exclusive.
  always_comb begin
    st_mie_d  = st_mie_q;
    st_mpie_d = st_mpie_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (trap_i) begin
      mepc_d    = pc_i & ~32'h3;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
      mcause_d  = trap_ext_i ? MCAUSE_IRQ_EXT : MCAUSE_IRQ_TIMER;
    end else if (eret_i) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else if (csr_we_i) begin
      case (csr_sel_i)
        CSR_MSTATUS: begin
          st_mie_d  = csr_wdata_i[MSTATUS_MIE_BIT];
          st_mpie_d = csr_wdata_i[MSTATUS_MPIE_BIT];
        end
        CSR_MEPC:   mepc_d   = csr_wdata_i & ~32'h3;
        CSR_MCAUSE: mcause_d = csr_wdata_i;
        default: ;
      endcase
    end
  end

  // MTIP: a tick always sets it (even during stall) and beats a
  // simultaneous software clear.
  always_comb begin
    mtip_d = mtip_q;
    if (csr_we_i && (csr_sel_i == CSR_MIP) && !csr_wdata_i[MIP_MTIP_BIT])
      mtip_d = 1'b0;
    if (tick_i)
      mtip_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      st_mie_q  <= 1'b0;
      st_mpie_q <= 1'b0;
      mepc_q    <= 32'h0;
      mcause_q  <= 32'h0;
      mtip_q    <= 1'b0;
    end else begin
      st_mie_q  <= st_mie_d;
      st_mpie_q <= st_mpie_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mtip_q    <= mtip_d;
    end
  end

  assign st_mie_o  = st_mie_q;
  assign st_mpie_o = st_mpie_q;
  assign mepc_o    = mepc_q;
  assign mcause_o  = mcause_q;
  assign mtip_o    = mtip_q;

endmodule

// File: rtl/rv_csr_exceptions.sv
// Machine-mode CSR file with interrupt/exception handling for a simple
// in-order RISC-V pipeline. CSR decode, read mux and read-modify-write
// live here; trap state lives in rv_csr_trap.
// Optional feature: define RV_CSR_COUNTERS_EN to expose the read-only
// cycle/time/cycleh/timeh counters; otherwise those addresses read 0.
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   x_stall_i, x_kill_i            stage stall / kill
//   d_valid_i, d_is_csr_i, d_is_eret_i   instruction qualifiers
//   d_fun_i, d_csr_imm_i, d_csr_sel_i    CSR op, immediate, address
//   d_rs1_i, d_pc_i                rs1 value, instruction PC
//   exp_irq_i, exp_tick_i          external IRQ level, timer tick pulse
//   csr_time_i, csr_cycles_i       free-running 40-bit counters
//   x_rd_o                         old CSR value (combinational)
//   x_exception_o                  interrupt trap taken (combinational)
//   x_exception_pc_o               mepc
module rv_csr_exceptions #(
  parameter logic [31:0] g_mie_reset = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        d_valid_i,
  input  logic        d_is_csr_i,
  input  logic        d_is_eret_i,
  input  logic [2:0]  d_fun_i,
  input  logic [4:0]  d_csr_imm_i,
  input  logic [11:0] d_csr_sel_i,
  input  logic [31:0] d_rs1_i,
  input  logic [31:0] d_pc_i,
  input  logic        exp_irq_i,
  input  logic        exp_tick_i,
  input  logic [39:0] csr_time_i,
  input  logic [39:0] csr_cycles_i,
  output logic [31:0] x_rd_o,
  output logic        x_exception_o,
  output logic [31:0] x_exception_pc_o
);

  import rv_csr_pkg::*;

  logic [31:0] mie_q, mie_d;
  logic        st_mie, st_mpie, mtip;
  logic [31:0] mepc, mcause;
  logic [31:0] mip, mstatus;
  logic [31:0] src, old_val, new_val;
  logic        csr_we, eret_ok, trap_take, ext_pending;

  always_comb begin
    mstatus = 32'h0;
    mstatus[MSTATUS_MIE_BIT]  = st_mie;
    mstatus[MSTATUS_MPIE_BIT] = st_mpie;
    mip = 32'h0;
    mip[MIP_MEIP_BIT] = exp_irq_i;
    mip[MIP_MTIP_BIT] = mtip;
  end

  // Read mux: always returns the pre-update value
  always_comb begin
    old_val = 32'h0;
    case (d_csr_sel_i)
      CSR_MSTATUS: old_val = mstatus;
      CSR_MIE:     old_val = mie_q;
      CSR_MEPC:    old_val = mepc;
      CSR_MCAUSE:  old_val = mcause;
      CSR_MIP:     old_val = mip;
`ifdef RV_CSR_COUNTERS_EN
      CSR_CYCLE:   old_val = csr_cycles_i[31:0];
      CSR_TIME:    old_val = csr_time_i[31:0];
      CSR_CYCLEH:  old_val = {24'h0, csr_cycles_i[39:32]};
      CSR_TIMEH:   old_val = {24'h0, csr_time_i[39:32]};
`endif
      default:     old_val = 32'h0;
    endcase
  end

`ifndef RV_CSR_COUNTERS_EN
  logic unused_counters;
  assign unused_counters = ^{csr_time_i, csr_cycles_i};
`endif

  assign x_rd_o = old_val;

  assign src     = d_fun_i[FUN_IMM_BIT] ? {27'h0, d_csr_imm_i} : d_rs1_i;
  assign new_val = csr_alu(d_fun_i[1:0], old_val, src);

  // Interrupt: globally enabled and at least one source pending-and-enabled
  assign x_exception_o = d_valid_i & ~x_kill_i & st_mie & (|(mip & mie_q));
  assign ext_pending   = exp_irq_i & mie_q[MIE_MEIE_BIT];
  assign trap_take     = x_exception_o & ~x_stall_i;

  assign csr_we  = d_is_csr_i & d_valid_i & ~x_kill_i & ~x_stall_i & ~x_exception_o
                   & (d_fun_i[1:0] != CSR_OP_NONE);
  assign eret_ok = d_is_eret_i & d_valid_i & ~x_kill_i & ~x_stall_i & ~x_exception_o;

  always_comb begin
    mie_d = mie_q;
    if (csr_we && (d_csr_sel_i == CSR_MIE))
      mie_d = new_val & MIE_WMASK;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) mie_q <= g_mie_reset & MIE_WMASK;
    else          mie_q <= mie_d;
  end

  rv_csr_trap u_trap (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .trap_i      (trap_take),
    .trap_ext_i  (ext_pending),
    .pc_i        (d_pc_i),
    .eret_i      (eret_ok),
    .csr_we_i    (csr_we),
    .csr_sel_i   (d_csr_sel_i),
    .csr_wdata_i (new_val),
    .tick_i      (exp_tick_i),
    .st_mie_o    (st_mie),
    .st_mpie_o   (st_mpie),
    .mepc_o      (mepc),
    .mcause_o    (mcause),
    .mtip_o      (mtip)
  );

  assign x_exception_pc_o = mepc;

endmodule

// File: tb/tb_rv_csr_exceptions.sv
module tb_rv_csr_exceptions;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_stall, x_kill, d_valid, d_is_csr, d_is_eret;
  logic [2:0]  d_fun;
  logic [4:0]  d_imm;
  logic [11:0] d_sel;
  logic [31:0] d_rs1, d_pc;
  logic        irq, tick;
  logic [39:0] ctime, ccyc;
  logic [31:0] x_rd, x_epc;
  logic        x_exc;

  int n_vec = 0;
  int n_err = 0;

  // Reference state, held as whole 32-bit CSR words
  logic [31:0] m_mstatus, m_mie, m_mepc, m_mcause;
  logic        m_mtip;

  rv_csr_exceptions #(.g_mie_reset(32'h0)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .x_stall_i(x_stall), .x_kill_i(x_kill), .d_valid_i(d_valid),
    .d_is_csr_i(d_is_csr), .d_is_eret_i(d_is_eret),
    .d_fun_i(d_fun), .d_csr_imm_i(d_imm), .d_csr_sel_i(d_sel),
    .d_rs1_i(d_rs1), .d_pc_i(d_pc),
    .exp_irq_i(irq), .exp_tick_i(tick),
    .csr_time_i(ctime), .csr_cycles_i(ccyc),
    .x_rd_o(x_rd), .x_exception_o(x_exc), .x_exception_pc_o(x_epc)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_mip();
    return (irq ? 32'h800 : 32'h0) | (m_mtip ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip();
`ifdef RV_CSR_COUNTERS_EN
      12'hC00: return ccyc[31:0];
      12'hC01: return ctime[31:0];
      12'hC80: return {24'h0, ccyc[39:32]};
      12'hC81: return {24'h0, ctime[39:32]};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_exc();
    return d_valid && !x_kill && m_mstatus[3] && ((m_mip() & m_mie) != 0);
  endfunction

  task automatic model_update();
    logic        exc, live, clr;
    logic [31:0] srcv, oldv, nv;
    if (!rst_n) begin
      m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0; m_mtip = 0;
      return;
    end
    exc  = m_exc();
    live = d_valid && !x_kill && !x_stall && !exc;
    clr  = 1'b0;
    if (exc && !x_stall) begin
      m_mepc    = {d_pc[31:2], 2'b00};
      m_mcause  = (irq && m_mie[11]) ? 32'h8000_000B : 32'h8000_0007;
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    end else if (live && d_is_eret) begin
      m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (live && d_is_csr && d_fun[1:0] != 2'b00) begin
      srcv = d_fun[2] ? {27'h0, d_imm} : d_rs1;
      oldv = m_read(d_sel);
      case (d_fun[1:0])
        2'b01:   nv = srcv;
        2'b10:   nv = oldv | srcv;
        default: nv = oldv & ~srcv;
      endcase
      case (d_sel)
        12'h300: m_mstatus = nv & 32'h88;
        12'h304: m_mie     = nv & 32'h880;
        12'h341: m_mepc    = {nv[31:2], 2'b00};
        12'h342: m_mcause  = nv;
        12'h344: clr       = !nv[7];
        default: ;
      endcase
    end
    if (tick)     m_mtip = 1'b1;
    else if (clr) m_mtip = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic set_idle();
    rst_n = 1; x_stall = 0; x_kill = 0; d_valid = 0; d_is_csr = 0; d_is_eret = 0;
    d_fun = 0; d_imm = 0; d_sel = 0; d_rs1 = 0; d_pc = 0; irq = 0; tick = 0;
  endtask

  // Compare outputs against the model, then advance one clock.
  // Called right after a negedge with inputs already driven.
  task automatic step();
    #1;
    if (rst_n) begin
      check_val("rd", x_rd, m_read(d_sel));
      check_val("exc", {31'h0, x_exc}, {31'h0, m_exc()});
      check_val("epc", x_epc, m_mepc);
    end
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
    d_sel = a;
    #1;
    check_val(tag, x_rd, exp);
  endtask

  task automatic csr_insn(input logic [2:0] f, input logic [11:0] a,
                          input logic [31:0] rs1, input logic [4:0] imm);
    set_idle();
    d_valid = 1; d_is_csr = 1; d_fun = f; d_sel = a; d_rs1 = rs1; d_imm = imm;
  endtask

  localparam int N_SEL = 10;
  logic [11:0] sel_tab [N_SEL] = '{12'h300, 12'h304, 12'h341, 12'h342, 12'h344,
                                   12'hC00, 12'hC01, 12'hC80, 12'hC81, 12'h123};

  initial begin
    ctime = 40'h0; ccyc = 40'h0;
    m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0; m_mtip = 0;
    set_idle();
    rst_n = 0;
    @(negedge clk);
    step(); step();
    set_idle();

    // reset state
    check_val("rst_exc", {31'h0, x_exc}, 32'h0);
    check_val("rst_epc", x_epc, 32'h0);
    peek("rst_mstatus", 12'h300, 32'h0);
    peek("rst_mie", 12'h304, 32'h0);
    step();

    // CSRRW mie <- 0x880: old value 0 visible in the same cycle
    csr_insn(3'b001, 12'h304, 32'h880, 5'd0);
    #1 check_val("rw_old", x_rd, 32'h0);
    step();
    set_idle();
    peek("rw_new", 12'h304, 32'h880);
    step();

    // CSRRSI / CSRRCI on mstatus
    csr_insn(3'b110, 12'h300, 32'h0, 5'd8); step();
    set_idle(); peek("rsi_mstatus", 12'h300, 32'h8); step();
    csr_insn(3'b111, 12'h300, 32'h0, 5'd8); step();
    set_idle(); peek("rci_mstatus", 12'h300, 32'h0); step();

    // timer interrupt
    csr_insn(3'b001, 12'h304, 32'h80, 5'd0); step();
    csr_insn(3'b110, 12'h300, 32'h0, 5'd8); step();
    set_idle(); tick = 1; step();
    set_idle(); peek("mtip_set", 12'h344, 32'h80); step();
    set_idle(); d_valid = 1; d_pc = 32'h1000;
    #1 check_val("tmr_exc", {31'h0, x_exc}, 32'h1);
    step();
    set_idle();
    peek("tmr_mepc", 12'h341, 32'h1000);
    peek("tmr_mcause", 12'h342, 32'h8000_0007);
    peek("tmr_mstatus", 12'h300, 32'h80);
    step();

    // clear MTIP then return from trap
    csr_insn(3'b001, 12'h344, 32'h0, 5'd0); step();
    set_idle(); peek("mip_clr", 12'h344, 32'h0); step();
    set_idle(); d_valid = 1; d_is_eret = 1; step();
    set_idle();
    peek("eret_mstatus", 12'h300, 32'h88);
    check_val("eret_epc", x_epc, 32'h1000);
    step();
    set_idle(); d_valid = 1; d_pc = 32'h2000;
    #1 check_val("no_exc", {31'h0, x_exc}, 32'h0);
    step();

    // external wins over timer; mepc low bits dropped
    csr_insn(3'b001, 12'h304, 32'h880, 5'd0); step();
    set_idle(); irq = 1; tick = 1; step();
    set_idle(); irq = 1; d_valid = 1; d_pc = 32'h2006; step();
    set_idle();
    peek("ext_mcause", 12'h342, 32'h8000_000B);
    check_val("ext_epc", x_epc, 32'h2004);
    step();
    csr_insn(3'b001, 12'h344, 32'h0, 5'd0); step();
    set_idle(); d_valid = 1; d_is_eret = 1; step();

    // stall holds a pending trap, kill suppresses it
    set_idle(); tick = 1; step();
    for (int i = 0; i < 3; i++) begin
      set_idle(); d_valid = 1; d_pc = 32'h3000; x_stall = 1;
      #1 check_val("stall_exc", {31'h0, x_exc}, 32'h1);
      step();
    end
    set_idle();
    check_val("stall_epc", x_epc, 32'h2004);
    peek("stall_mstatus", 12'h300, 32'h88);
    step();
    set_idle(); d_valid = 1; d_pc = 32'h3000; x_kill = 1;
    #1 check_val("kill_exc", {31'h0, x_exc}, 32'h0);
    step();
    set_idle(); d_valid = 1; d_pc = 32'h3000; step();
    set_idle(); check_val("trap_epc", x_epc, 32'h3000); step();
    csr_insn(3'b001, 12'h344, 32'h0, 5'd0); step();
    set_idle(); d_valid = 1; d_is_eret = 1; step();

    // counters
    set_idle();
    ccyc = 40'h12_3456_789A; ctime = 40'hAB_CDEF_0123;
`ifdef RV_CSR_COUNTERS_EN
    peek("cycle", 12'hC00, 32'h3456_789A);
    peek("cycleh", 12'hC80, 32'h12);
    peek("timeh", 12'hC81, 32'hAB);
`else
    peek("cycle", 12'hC00, 32'h0);
    peek("cycleh", 12'hC80, 32'h0);
    peek("timeh", 12'hC81, 32'h0);
`endif
    step();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      rst_n    = ($urandom_range(0, 299) != 0);
      x_stall  = ($urandom_range(0, 3) == 0);
      x_kill   = ($urandom_range(0, 7) == 0);
      d_valid  = ($urandom_range(0, 3) != 0);
      d_is_csr = ($urandom_range(0, 1) == 1);
      d_is_eret = !d_is_csr && ($urandom_range(0, 9) == 0);
      d_fun    = 3'($urandom_range(0, 7));
      d_imm    = 5'($urandom);
      d_sel    = sel_tab[$urandom_range(0, N_SEL - 1)];
      case ($urandom_range(0, 2))
        0:       d_rs1 = $urandom;
        1:       d_rs1 = 32'h88;
        default: d_rs1 = 32'h880;
      endcase
      d_pc  = $urandom;
      irq   = ($urandom_range(0, 3) == 0);
      tick  = ($urandom_range(0, 7) == 0);
      ctime = {8'($urandom), 32'($urandom)};
      ccyc  = {8'($urandom), 32'($urandom)};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_csr_exceptions.md
RV_CSR_EXCEPTIONS -- requirements
Module: rv_csr_exceptions

Interface
REQ-001 SHALL have parameter: g_mie_reset, 32'h0, reset value of mie.
REQ-002 SHALL have port: clk_i  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n_i  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: x_stall_i, x_kill_i, d_valid_i  in  1 each  stage stall, stage kill, instruction valid.
REQ-005 SHALL have ports: d_is_csr_i, d_is_eret_i  in  1 each  CSR instruction, return-from-trap instruction.
REQ-006 SHALL have ports: d_fun_i  in  3  CSR op; d_csr_imm_i  in  5  immediate; d_csr_sel_i  in  12  CSR address.
REQ-007 SHALL have ports: d_rs1_i, d_pc_i  in  32 each  rs1 value, instruction PC.
REQ-008 SHALL have ports: exp_irq_i, exp_tick_i  in  1 each  external IRQ level, timer tick pulse.
REQ-009 SHALL have ports: csr_time_i, csr_cycles_i  in  40 each  free-running counters.
REQ-010 SHALL have ports: x_rd_o  out  32  CSR read value; x_exception_o  out  1  trap taken; x_exception_pc_o  out  32  mepc.

Function
REQ-011 SHALL decode CSRs: mstatus 0x300, mie 0x304, mepc 0x341, mcause 0x342, mip 0x344, cycle 0xC00, time 0xC01, cycleh 0xC80, timeh 0xC81; other addresses read 0, ignore writes.
REQ-012 SHALL drive x_rd_o combinationally with the old CSR value; cycleh/timeh return counter bits [39:32] zero-extended.
REQ-013 SHALL form source = d_rs1_i for d_fun_i 001/010/011 and zero-extended d_csr_imm_i for 101/110/111.
REQ-014 SHALL compute new value: x01 -> source; x10 -> old|source; x11 -> old&~source; 000/100 -> no write.
REQ-015 SHALL commit a CSR write on the clock edge when d_is_csr_i & d_valid_i & !x_kill_i & !x_stall_i & !x_exception_o; counters are read-only.
REQ-016 SHALL implement mstatus bit3 MIE and bit7 MPIE; all other mstatus bits read 0.
REQ-017 SHALL implement mie bits 7 (MTIE) and 11 (MEIE) writable; other bits read 0.
REQ-018 SHALL implement mip bit11 = exp_irq_i (live, read-only) and bit7 = sticky MTIP, set by exp_tick_i, cleared only by CSR write of 0 to bit7; set wins over a simultaneous clear.
REQ-019 SHALL assert x_exception_o combinationally = d_valid_i & !x_kill_i & MIE & |(mip & mie).
REQ-020 SHALL, on an edge with x_exception_o & !x_stall_i: mepc <= d_pc_i; MPIE <= MIE; MIE <= 0; mcause <= 0x8000000B if external pending-enabled, else 0x80000007 (external has priority).
REQ-021 SHALL, on an edge with d_is_eret_i & d_valid_i & !x_kill_i & !x_stall_i & !x_exception_o: MIE <= MPIE; MPIE <= 1.
REQ-022 SHALL drive x_exception_pc_o = mepc continuously; mepc bits [1:0] forced to 0 on write.
REQ-023 SHALL hold all state while x_stall_i=1, except the MTIP sticky set, which is never lost.

Reset
REQ-024 SHALL, while rst_n_i=0 at an edge, clear mstatus, mepc, mcause, MTIP and load mie with g_mie_reset; outputs follow combinationally (x_exception_o=0, x_exception_pc_o=0).

Configuration
REQ-025 SHALL, with RV_CSR_COUNTERS_EN defined, expose cycle/time/cycleh/timeh as in REQ-011/012; without it those addresses read 0 and csr_time_i/csr_cycles_i are unused.

Structure
REQ-026 SHALL place CSR addresses, mstatus/mip/mie bit indices, mcause codes and d_fun_i encodings in shared package rv_csr_pkg.
REQ-027 SHALL contain one sub-module, rv_csr_trap, holding mstatus/mepc/mcause/MTIP and the trap/eret logic; the CSR decode/ALU stays in the top.

Verification
REQ-028 SHALL test CSRRW 0x304 with rs1=0x880 -> x_rd_o=0x0 that cycle, next read of 0x304 returns 0x880.
REQ-029 SHALL test CSRRSI 0x300 imm=8 then CSRRCI imm=8 -> mstatus reads 0x8 then 0x0.
REQ-030 SHALL test mie=0x80, MIE=1, exp_tick_i pulse, valid insn at pc=0x1000 -> x_exception_o=1, mepc=0x1000, mcause=0x80000007, mstatus=0x80.
REQ-031 SHALL test eret after REQ-030 -> x_exception_pc_o=0x1000, mstatus=0x88; writing mip=0 clears MTIP and x_exception_o stays 0.
REQ-032 SHALL test csr_cycles_i=40'h12_3456_789A -> read 0xC00 = 0x3456789A, 0xC80 = 0x12; without RV_CSR_COUNTERS_EN both read 0.
REQ-033 SHALL test trap pending with x_stall_i=1 for 3 cycles -> no state change until stall drops; x_kill_i=1 -> x_exception_o=0.
